code_decoder: RTL and testbench

//  Binary-to-one-hot decoder with a buffered valid/ready stream interface; the inverse of the 4:2 priority encoder.

---
 rtl/code_decoder_pkg.sv | 18 +
 rtl/code_decoder_if.sv | 17 +
 rtl/code_decoder_sync_fifo.sv | 38 +++
 rtl/code_decoder.sv | 30 +++
 tb/tb_code_decoder.sv | 119 +++++++++++
 5 files changed

// File: rtl/code_decoder_pkg.sv
// code_decoder_pkg: shared widths, the stored entry layout and the one-hot decode
package code_decoder_pkg;
    localparam int CODE_W = 2;
    localparam int DEPTH  = 4;
    localparam int OUT_W  = 1 << CODE_W;
    localparam int LVL_W  = $clog2(DEPTH + 1);
    localparam int ENT_W  = CODE_W + 1;
    localparam int ENT_EN = CODE_W;

    typedef struct packed {
        logic              en;
        logic [CODE_W-1:0] code;
    } entry_t;

    function automatic logic [OUT_W-1:0] decode(entry_t e);
        return e.en ? OUT_W'(1) << e.code : '0;
    endfunction
endpackage

// File: rtl/code_decoder_if.sv
// code_decoder_if: code-in / one-hot-out stream bundle with producer and decoder views
interface code_decoder_if;
    import code_decoder_pkg::*;
    logic              in_valid;
    logic              in_ready;
    logic [CODE_W-1:0] Code;
    logic              Enable;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  Data;
    logic [LVL_W-1:0]  level;

    modport master (output in_valid, Code, Enable, out_ready,
                    input  in_ready, out_valid, Data, level);
    modport slave  (input  in_valid, Code, Enable, out_ready,
                    output in_ready, out_valid, Data, level);
endinterface

// File: rtl/code_decoder_sync_fifo.sv
// sync_fifo: single-clock FIFO; occupancy tracked in level, pointers wrap at DEPTH
module sync_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam int PW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                level <= level + 1'b1;
            else if (pop && !push)
                level <= level - 1'b1;
        end
    end

    assign head = mem[rd_ptr];
endmodule

// File: rtl/code_decoder.sv
// code_decoder: buffered binary-to-one-hot decoder with valid/ready on both sides
module code_decoder
    import code_decoder_pkg::*;
(
    input logic          clk,
    input logic          rst,
    code_decoder_if.slave bus
);
    entry_t           head;
    logic [ENT_W-1:0] head_raw;
    logic             push, pop;

    // ready/valid depend only on registered occupancy, never on the opposite side
    assign bus.in_ready  = bus.level != LVL_W'(DEPTH);
    assign bus.out_valid = bus.level != '0;
    assign push          = bus.in_valid & bus.in_ready;
    assign pop           = bus.out_valid & bus.out_ready;
    assign head          = entry_t'(head_raw);
    assign bus.Data      = bus.out_valid ? decode(head) : '0;

    sync_fifo #(.WIDTH(ENT_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   ({bus.Enable, bus.Code}),
        .head  (head_raw),
        .level (bus.level)
    );
endmodule

// File: tb/tb_code_decoder.sv
// tb_code_decoder: directed and random stimulus against a queue-based reference model
module tb_code_decoder;
    import code_decoder_pkg::*;

    typedef struct {
        logic              en;
        logic [CODE_W-1:0] code;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    ent_t q[$];

    code_decoder_if bus();
    code_decoder dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic check(string tag);
        logic [31:0] ed = 0;
        if (q.size() != 0 && q[0].en)
            ed = 32'(2 ** q[0].code);
        chk({tag, ".level"},     32'(bus.level),     32'(q.size()));
        chk({tag, ".in_ready"},  32'(bus.in_ready),  32'(q.size() != DEPTH));
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(q.size() != 0));
        chk({tag, ".data"},      32'(bus.Data),      ed);
    endtask

    task automatic cycle(string tag, logic r, logic iv, logic [CODE_W-1:0] c, logic e, logic ordy);
        bit do_push, do_pop;
        rst           = r;
        bus.in_valid  = iv;
        bus.Code      = c;
        bus.Enable    = e;
        bus.out_ready = ordy;
        do_push = iv && q.size() < DEPTH;
        do_pop  = ordy && q.size() > 0;
        @(posedge clk);
        if (r)
            q.delete();
        else begin
            if (do_pop)
                void'(q.pop_front());
            if (do_push)
                q.push_back('{e, c});
        end
        @(negedge clk);
        check(tag);
    endtask

    initial begin
        int idx;
        bus.in_valid  = 1'b0;
        bus.Code      = '0;
        bus.Enable    = 1'b0;
        bus.out_ready = 1'b0;

        for (int k = 0; k < 3; k++)
            cycle("reset", 1, 1, 2'(k), 1, 1);

        for (int k = 0; k < 4; k++) begin
            cycle("decode", 0, 1, 2'(k), 1, 1);
            chk("decode.onehot", 32'(bus.Data), 32'(1 << k));
        end
        cycle("decode.drain", 0, 0, 0, 0, 1);

        cycle("en0", 0, 1, 2'b11, 0, 0);
        chk("en0.data_zero", 32'(bus.Data), 32'd0);
        cycle("en0.drain", 0, 0, 0, 0, 1);

        for (int k = 0; k < 5; k++)
            cycle("fill", 0, 1, 2'(k), 1, 0);
        chk("fill.full_level", 32'(bus.level), 32'(DEPTH));
        chk("fill.full_ready", 32'(bus.in_ready), 32'd0);
        cycle("stall.pop", 0, 1, 2'd0, 1, 1);
        chk("stall.ready_back", 32'(bus.in_ready), 32'd1);
        cycle("stall.refill", 0, 1, 2'd0, 1, 0);
        for (int k = 0; k < 5; k++)
            cycle("stall.drain", 0, 0, 0, 0, 1);

        idx = 0;
        for (int k = 0; k < 60 && idx < 10; k++) begin
            logic was_ready;
            was_ready = bus.in_ready;
            cycle("wrap", 0, 1, 2'(idx % 4), 1, 1'(k % 2));
            if (was_ready)
                idx++;
        end
        chk("wrap.all_pushed", 32'(idx), 32'd10);
        for (int k = 0; k < 6; k++)
            cycle("wrap.drain", 0, 0, 0, 0, 1);

        for (int k = 0; k < 3; k++)
            cycle("mid.fill", 0, 1, 2'(k), 1, 0);
        chk("mid.level3", 32'(bus.level), 32'd3);
        cycle("mid.reset", 1, 1, 2'd3, 1, 0);
        chk("mid.level0", 32'(bus.level), 32'd0);
        cycle("mid.push", 0, 1, 2'b01, 1, 0);
        chk("mid.data", 32'(bus.Data), 32'b0010);
        cycle("mid.drain", 0, 0, 0, 0, 1);

        for (int k = 0; k < 400; k++)
            cycle("rand", ($urandom_range(0, 49) == 0), 1'($urandom), 2'($urandom),
                  1'($urandom), 1'($urandom));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
